// File: rtl/fft_sample_loader.sv
// fft_sample_loader
// -----------------
// Write-side front end of the radix-2 FFT. It takes one frame of N = 2^ADDR_W
// complex samples from a valid/ready stream. It writes each sample into the FFT
// input memory, in bit-reversed address order when BIT_REVERSE = 1. It then
// issues a two-cycle start_fft pulse and follows the core's fft_done level
// through one full run. Only after that run does it accept the next frame.
//
// Handshake: a beat transfers on any rising edge where s_valid & s_ready.
// s_ready is combinational and is high only while loading. The source may hold
// s_valid high at any time. Beats offered outside LOAD are ignored and are not
// buffered.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   s_valid/s_ready       sample stream handshake
//   s_data, s_last        sample payload; last-beat-of-frame marker
//   mem_we/addr/wdata     registered write port to the FFT input memory
//   start_fft             two-cycle start request to the FFT core
//   fft_done              core status: high = idle/finished, low = running
//   frame_done            one-cycle pulse when the loaded frame's FFT run ends
//   err_frame             one-cycle pulse on a framing error
//   frame_cnt             completed frames, wraps 255 -> 0
//   dbg_state             current FSM state, for observation only
module fft_sample_loader #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 64,
    parameter int BIT_REVERSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start_fft,
    input  logic              fft_done,
    output logic              frame_done,
    output logic              err_frame,
    output logic [7:0]        frame_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt, cnt_nx;
    // Sub-phase inside START: 0 = idle cycle for the final write,
    // 1..2 = start_fft high, 3 = drop start_fft and move on.
    logic [1:0]          st_cnt, st_cnt_nx;
    logic                mem_we_nx;
    logic [ADDR_W-1:0]   mem_addr_nx;
    logic [DATA_W-1:0]   mem_wdata_nx;
    logic                start_fft_nx;
    logic                frame_done_nx;
    logic                err_frame_nx;
    logic [7:0]          frame_cnt_nx;
    logic                beat_acc;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            r[b] = a[ADDR_W-1-b];
        end
        return r;
    endfunction

    assign s_ready   = (state == LOAD);
    assign beat_acc  = s_valid & s_ready;
    assign dbg_state = state;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        st_cnt_nx     = st_cnt;
        mem_we_nx     = 1'b0;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        start_fft_nx  = start_fft;
        frame_done_nx = 1'b0;
        err_frame_nx  = 1'b0;
        frame_cnt_nx  = frame_cnt;

        case (state)
            LOAD: begin
                if (beat_acc) begin
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = (BIT_REVERSE != 0) ? bitrev(cnt) : cnt;
                    mem_wdata_nx = s_data;
                    if (cnt == LAST_IDX) begin
                        // Full frame: process it even if s_last was missing,
                        // but flag the missing marker.
                        cnt_nx       = '0;
                        err_frame_nx = ~s_last;
                        st_cnt_nx    = 2'd0;
                        state_nx     = START;
                    end else if (s_last) begin
                        // Short frame: the write already went out; drop the
                        // partial frame and restart from beat 0.
                        cnt_nx       = '0;
                        err_frame_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + ADDR_W'(1);
                    end
                end
            end
            START: begin
                case (st_cnt)
                    2'd0: st_cnt_nx = 2'd1;
                    2'd1: begin
                        start_fft_nx = 1'b1;
                        st_cnt_nx    = 2'd2;
                    end
                    2'd2: st_cnt_nx = 2'd3;
                    default: begin
                        start_fft_nx = 1'b0;
                        st_cnt_nx    = 2'd0;
                        state_nx     = WAIT_LOW;
                    end
                endcase
            end
            WAIT_LOW: begin
                if (!fft_done) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (fft_done) begin
                    frame_done_nx = 1'b1;
                    frame_cnt_nx  = frame_cnt + 8'd1;
                    state_nx      = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            st_cnt     <= 2'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            start_fft  <= 1'b0;
            frame_done <= 1'b0;
            err_frame  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            st_cnt     <= st_cnt_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            start_fft  <= start_fft_nx;
            frame_done <= frame_done_nx;
            err_frame  <= err_frame_nx;
            frame_cnt  <= frame_cnt_nx;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader
// Drives two loaders from the same stream: one writes in bit-reversed address
// order and one in linear order. Each cycle both are checked against
// expectations from a frame-level model: beat position in the frame, reversed
// index by arithmetic, start/done timeline, and frame count.
module tb_fft_sample_loader;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int N  = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          fft_done;

    logic          rev_ready, lin_ready;
    logic          rev_we, lin_we;
    logic [AW-1:0] rev_addr, lin_addr;
    logic [DW-1:0] rev_wdata, lin_wdata;
    logic          rev_start, lin_start;
    logic          rev_fdone, lin_fdone;
    logic          rev_err, lin_err;
    logic [7:0]    rev_cnt, lin_cnt;
    logic [1:0]    rev_dbg, lin_dbg;

    fft_sample_loader #(.ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rev_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(rev_we), .mem_addr(rev_addr),
        .mem_wdata(rev_wdata), .start_fft(rev_start), .fft_done(fft_done),
        .frame_done(rev_fdone), .err_frame(rev_err), .frame_cnt(rev_cnt),
        .dbg_state(rev_dbg)
    );

    fft_sample_loader #(.ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(lin_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(lin_we), .mem_addr(lin_addr),
        .mem_wdata(lin_wdata), .start_fft(lin_start), .fft_done(fft_done),
        .frame_done(lin_fdone), .err_frame(lin_err), .frame_cnt(lin_cnt),
        .dbg_state(lin_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: run did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- model state ----------------
    int         vectors     = 0;
    int         miscompares = 0;
    int         pos;
    logic       exp_we, exp_start, exp_fdone, exp_err, exp_ready;
    logic [AW-1:0] exp_addr_rev, exp_addr_lin;
    logic [DW-1:0] exp_data;
    logic [7:0]    exp_cnt;

    function automatic int rev_model(input int i);
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) begin
            if (((i >> b) & 1) != 0) r += 1 << (AW - 1 - b);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic clear_pulses();
        exp_we    = 1'b0;
        exp_start = 1'b0;
        exp_fdone = 1'b0;
        exp_err   = 1'b0;
    endtask

    // Advance one clock, then compare every output at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("rev.mem_we", 64'(rev_we), 64'(exp_we));
        chk("lin.mem_we", 64'(lin_we), 64'(exp_we));
        if (exp_we) begin
            chk("rev.mem_addr", 64'(rev_addr), 64'(exp_addr_rev));
            chk("lin.mem_addr", 64'(lin_addr), 64'(exp_addr_lin));
            chk("rev.mem_wdata", rev_wdata, exp_data);
            chk("lin.mem_wdata", lin_wdata, exp_data);
        end
        chk("rev.start_fft", 64'(rev_start), 64'(exp_start));
        chk("lin.start_fft", 64'(lin_start), 64'(exp_start));
        chk("rev.frame_done", 64'(rev_fdone), 64'(exp_fdone));
        chk("lin.frame_done", 64'(lin_fdone), 64'(exp_fdone));
        chk("rev.err_frame", 64'(rev_err), 64'(exp_err));
        chk("lin.err_frame", 64'(lin_err), 64'(exp_err));
        chk("rev.frame_cnt", 64'(rev_cnt), 64'(exp_cnt));
        chk("lin.frame_cnt", 64'(lin_cnt), 64'(exp_cnt));
        chk("rev.s_ready", 64'(rev_ready), 64'(exp_ready));
        chk("lin.s_ready", 64'(lin_ready), 64'(exp_ready));
        chk("state_match", 64'(rev_dbg), 64'(lin_dbg));
        clear_pulses();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".rev.mem_we"}, 64'(rev_we), 64'd0);
        chk({tag, ".lin.mem_we"}, 64'(lin_we), 64'd0);
        chk({tag, ".rev.mem_addr"}, 64'(rev_addr), 64'd0);
        chk({tag, ".lin.mem_addr"}, 64'(lin_addr), 64'd0);
        chk({tag, ".rev.mem_wdata"}, rev_wdata, 64'd0);
        chk({tag, ".lin.mem_wdata"}, lin_wdata, 64'd0);
        chk({tag, ".rev.start_fft"}, 64'(rev_start), 64'd0);
        chk({tag, ".lin.start_fft"}, 64'(lin_start), 64'd0);
        chk({tag, ".rev.frame_done"}, 64'(rev_fdone), 64'd0);
        chk({tag, ".rev.err_frame"}, 64'(rev_err), 64'd0);
        chk({tag, ".rev.frame_cnt"}, 64'(rev_cnt), 64'd0);
        chk({tag, ".lin.frame_cnt"}, 64'(lin_cnt), 64'd0);
        chk({tag, ".rev.s_ready"}, 64'(rev_ready), 64'd1);
    endtask

    // Called just after a falling edge: assert reset mid-cycle, check that the
    // outputs clear without waiting for a clock, then release on the next
    // falling edge.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        @(negedge clk);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        fft_done = 1'b1;
        rst_n    = 1'b1;
        pos       = 0;
        exp_cnt   = 8'd0;
        exp_ready = 1'b1;
        clear_pulses();
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_frame(input int nbeats, input int last_idx,
                              input bit seq_data, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    s_data  = {$urandom, $urandom};
                    s_last  = 1'($urandom_range(0, 1));
                    step();
                end
            end
            s_valid = 1'b1;
            s_data  = seq_data ? 64'(i) : {$urandom, $urandom};
            s_last  = (i == last_idx);
            exp_we       = 1'b1;
            exp_addr_lin = AW'(pos);
            exp_addr_rev = AW'(rev_model(pos));
            exp_data     = s_data;
            if (pos == N - 1) begin
                exp_err   = ~s_last;
                exp_ready = 1'b0;
                pos       = 0;
            end else if (s_last) begin
                exp_err = 1'b1;
                pos     = 0;
            end else begin
                pos++;
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic noise(input bit en);
        if (en) begin
            s_valid = 1'($urandom_range(0, 1));
            s_last  = 1'($urandom_range(0, 1));
            s_data  = {$urandom, $urandom};
        end
    endtask

    // Follows a completed frame: start pulse timeline plus a modelled core.
    // drop_delay < 0 drops fft_done while start_fft is still high.
    task automatic run_fft(input int drop_delay, input int run_len, input bit nz);
        noise(nz); step();                         // idle cycle, final write lands
        noise(nz); exp_start = 1'b1; step();
        noise(nz); exp_start = 1'b1;
        if (drop_delay < 0) fft_done = 1'b0;
        step();
        noise(nz); step();                         // start_fft low again
        for (int d = 0; d < drop_delay; d++) begin
            noise(nz); step();
        end
        fft_done = 1'b0;
        for (int r = 0; r < run_len; r++) begin
            noise(nz); step();
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        fft_done  = 1'b1;
        exp_fdone = 1'b1;
        exp_cnt   = exp_cnt + 8'd1;
        exp_ready = 1'b1;
        step();
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        fft_done = 1'b1;
        pos       = 0;
        exp_cnt   = 8'd0;
        exp_ready = 1'b1;
        exp_addr_rev = '0;
        exp_addr_lin = '0;
        exp_data     = '0;
        clear_pulses();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // Frame of data 0..31, core drops 3 cycles after start and runs 100.
        load_frame(N, N - 1, 1'b1, 1'b0);
        run_fft(0, 100, 1'b0);

        // Early s_last on beat 9: error, no start; next frame starts at address 0.
        load_frame(10, 9, 1'b0, 1'b0);
        repeat (6) step();
        load_frame(N, N - 1, 1'b0, 1'b0);
        run_fft(-1, 1, 1'b1);

        // Missing s_last on beat 31 with a gappy source: error, still processed.
        load_frame(N, -1, 1'b0, 1'b1);
        run_fft(2, 7, 1'b1);

        // Reset during beat 20.
        load_frame(20, -1, 1'b0, 1'b1);
        s_valid = 1'b1;
        s_data  = {$urandom, $urandom};
        mid_reset("rst_beat20");
        step();

        // Complete one frame, then reset during WAIT_DONE.
        load_frame(N, N - 1, 1'b0, 1'b0);
        run_fft(0, 3, 1'b0);
        load_frame(N, N - 1, 1'b0, 1'b0);
        step();
        exp_start = 1'b1; step();
        exp_start = 1'b1; step();
        step();
        fft_done = 1'b0;
        repeat (5) step();
        mid_reset("rst_wait_done");
        step();

        // Reset while start_fft is high.
        load_frame(N, N - 1, 1'b0, 1'b0);
        step();
        exp_start = 1'b1; step();
        mid_reset("rst_start");
        step();

        // 256 complete frames: frame_cnt wraps back to 0.
        for (int f = 0; f < 256; f++) begin
            load_frame(N, N - 1, 1'b0, 1'($urandom_range(0, 1)));
            run_fft(int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 5)), 1'b1);
        end
        chk("wrap.rev.frame_cnt", 64'(rev_cnt), 64'd0);
        chk("wrap.lin.frame_cnt", 64'(lin_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Write-side front end for the radix-2 FFT datapath. Accepts a stream of complex samples over a valid/ready handshake and writes one full frame into the FFT input memory, in bit-reversed address order when required. After the last write it issues the two-cycle `start_fft` pulse the FFT core expects. It then tracks the core's `fft_done` level through one complete run before accepting the next frame. It is the writer that feeds the memory the result checker later reads.

## Interface
Parameters:
- `ADDR_W`, 5: memory address width; frame length N = 2^ADDR_W.
- `DATA_W`, 64: sample width (packed real/imag).
- `BIT_REVERSE`, 1: 1 = write sample i to address bitrev(i); 0 = write to address i.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  sample beat valid.
- `s_ready`  out  1  loader accepts a beat.
- `s_data`  in  DATA_W  sample payload.
- `s_last`  in  1  marks the final beat of a frame.
- `mem_we`  out  1  input-memory write enable.
- `mem_addr`  out  ADDR_W  input-memory write address.
- `mem_wdata`  out  DATA_W  input-memory write data.
- `start_fft`  out  1  FFT start request.
- `fft_done`  in  1  FFT core status: high when idle or finished, low while running.
- `frame_done`  out  1  one-cycle pulse when the FFT run for the loaded frame completes.
- `err_frame`  out  1  one-cycle pulse on a framing error.
- `frame_cnt`  out  8  completed frames; wraps at 255 -> 0.

## Operation
- A beat is accepted on any rising edge where `s_valid & s_ready`.
- `s_ready` is combinational: high only in state LOAD.
- Beat counter `cnt` (ADDR_W bits) indexes the beats of the current frame.
- **Reset** (`rst_n` low, asynchronous):
  - state -> LOAD, `cnt` = 0.
  - `mem_we`, `start_fft`, `frame_done` and `err_frame` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `frame_cnt` = 0.
- **LOAD**, on an accepted beat:
  - Register `mem_we` = 1, `mem_addr` = BIT_REVERSE ? bitrev(cnt) : cnt, `mem_wdata` = `s_data`.
  - Then `cnt` increments.
  - When no beat is accepted, `mem_we` = 0 the following cycle.
- **Early `s_last`** (accepted with `cnt` < N-1):
  - The write still occurs.
  - `err_frame` pulses, `cnt` -> 0, state stays LOAD; the partial frame is discarded.
- **Beat `cnt` = N-1:**
  - Write occurs and `cnt` -> 0; state -> START.
  - If `s_last` = 0 on this beat, `err_frame` also pulses; the frame is still processed.
- **START:**
  - One idle cycle lets the final write land.
  - Then `start_fft` = 1 for exactly 2 cycles; state -> WAIT_LOW.
- **WAIT_LOW:** hold until `fft_done` = 0 (core has begun).
- **WAIT_DONE:**
  - Hold until `fft_done` = 1.
  - Then pulse `frame_done` for one cycle, increment `frame_cnt`, state -> LOAD.
- `s_valid` held high outside LOAD is ignored; there is no buffering and no lost-data flag.

## Timing
- Last beat accepted at edge k:
  - `mem_we` is high during cycle k..k+1 and is sampled by the RAM at edge k+1.
  - `start_fft` is high for cycles starting at edges k+2 and k+3, low from edge k+4.
- `s_ready` drops in the cycle after edge k.
- Write latency: exactly one cycle from beat acceptance to `mem_we`. Back-to-back beats give back-to-back writes, one per cycle.
- Minimum frame-to-frame gap: N beats + 3 cycles + FFT run time + 1 cycle.
- `fft_done` already low at the first WAIT_LOW cycle: advance on the next edge.
- `fft_done` rising in the same cycle the state enters WAIT_DONE is honoured on that edge.
- `frame_done` and the return to LOAD occur on the same edge. `s_ready` is high the cycle after `frame_done` rises.
- Reset asserted mid-frame or mid-FFT:
  - All outputs return to reset values immediately and the partial frame is lost.
  - `start_fft` deasserts asynchronously.

## Test plan
- Reset -> all outputs 0 and `s_ready` = 1 after release. Stream 32 beats with `s_data` = i (`s_last` on beat 31) -> 32 writes with addresses 0,16,8,24,4,…,31 carrying data 0..31. `start_fft` high for exactly 2 cycles starting 2 cycles after the last beat.
- Same run with BIT_REVERSE = 0 -> `mem_addr` = 0..31 in order.
- Model the core: `fft_done` drops 3 cycles after `start_fft` and rises 100 cycles later -> single `frame_done` pulse, `frame_cnt` = 1, `s_ready` high the next cycle.
- `s_last` on beat 9 -> `err_frame` pulse, no `start_fft`. Next 32-beat frame writes from address bitrev(0) = 0 and runs normally.
- No `s_last` on beat 31 -> `err_frame` pulse and `start_fft` still issued. Also toggle `s_valid` randomly during LOAD -> one write per accepted beat only, `cnt` never skips.
- `rst_n` pulsed low during beat 20, and separately during WAIT_DONE -> outputs clear asynchronously, `frame_cnt` = 0. The following frame completes correctly. Run 256 frames -> `frame_cnt` wraps to 0.
